// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle core and its instruction sequencer.
package proc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalted,
    StFault
  } seq_state_e;

  typedef enum logic [1:0] {
    CauseNone   = 2'd0,
    CauseHalt   = 2'd1,
    CauseEbreak = 2'd2,
    CauseStep   = 2'd3
  } halt_cause_e;

  typedef enum logic [1:0] {
    FaultNone     = 2'd0,
    FaultMisalign = 2'd1,
    FaultRange    = 2'd2,
    FaultTimeout  = 2'd3
  } fault_code_e;

  localparam logic [31:0] CmdNop    = 32'h0000_0013;  // ADDI x0,x0,0
  localparam logic [31:0] CmdPark   = 32'h0000_0063;  // BEQ x0,x0,0: spin in place
  localparam logic [31:0] CmdEbreak = 32'h0010_0073;

  localparam logic [6:0] OpcOpImm  = 7'h13;
  localparam logic [6:0] OpcOp     = 7'h33;
  localparam logic [6:0] OpcBranch = 7'h63;
  localparam logic [6:0] OpcJal    = 7'h6f;

endpackage

// File: rtl/seq_imem.sv
// Instruction store: one synchronous write port, asynchronous read, no reset.
module seq_imem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Word write from the load port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Feeds command words to the memory-less core, owns its reset, and provides
// start/halt/step/resume control with PC and hang fault detection.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned AW      = 6,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic          halt_req,
  input  logic          step,
  input  logic          resume,
  input  logic          step_mode,
  input  logic          clear,
  input  logic [31:0]   cpu_pc,
  input  logic          cpu_done,
  output logic [31:0]   cmd,
  output logic          cpu_reset,
  output logic          busy,
  output logic          halted,
  output logic          fault,
  output logic [1:0]    cause,
  output logic [1:0]    fault_code,
  output logic [31:0]   retired
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  seq_state_e     state_q, state_d;
  halt_cause_e    cause_q, cause_d;
  fault_code_e    fcode_q, fcode_d;
  logic           slot_q, slot_d;
  logic           halt_pend_q, halt_pend_d;  // halt_req or step seen since the last slot
  logic           sm_pend_q, sm_pend_d;      // step_mode was high at the last retire
  logic           go_q, go_d;                // resume/step waiting for the next slot
  logic           go_step_q, go_step_d;
  logic           inflight_q, inflight_d;    // a program instruction (not PARK) is executing
  logic [WdW-1:0] wdog_q, wdog_d, wdog_inc;
  logic [31:0]    retired_q, retired_d;
  logic [31:0]    mem_word;
  logic           mem_we, pc_misaligned, pc_out_range;

  seq_imem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (cpu_pc[AW+1:2]),
    .rdata (mem_word)
  );

  assign pc_misaligned = |cpu_pc[1:0];
  assign pc_out_range  = cpu_pc[31:2] >= 30'(DEPTH);
  assign wdog_inc      = wdog_q + WdW'(1);

  // Next-state, slot feed and bookkeeping.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    fcode_d     = fcode_q;
    slot_d      = 1'b0;
    halt_pend_d = halt_pend_q;
    sm_pend_d   = sm_pend_q;
    go_d        = go_q;
    go_step_d   = go_step_q;
    inflight_d  = inflight_q;
    wdog_d      = wdog_q;
    retired_d   = retired_q;
    mem_we      = 1'b0;
    cmd         = CmdNop;

    case (state_q)
      StIdle: begin
        mem_we = load_en;
        if (start) begin
          state_d     = StRun;
          slot_d      = 1'b1;
          retired_d   = '0;
          cause_d     = CauseNone;
          halt_pend_d = 1'b0;
          sm_pend_d   = 1'b0;
          go_d        = 1'b0;
          go_step_d   = 1'b0;
          inflight_d  = 1'b0;
          wdog_d      = '0;
        end
      end

      StRun: begin
        if (halt_req) halt_pend_d = 1'b1;
        if (slot_q) begin
          wdog_d     = WdW'(1);
          inflight_d = 1'b0;
          if (pc_misaligned) begin
            state_d = StFault;
            fcode_d = FaultMisalign;
          end else if (pc_out_range) begin
            state_d = StFault;
            fcode_d = FaultRange;
          end else if (halt_pend_q || halt_req || sm_pend_q) begin
            cmd         = CmdPark;
            state_d     = StHalted;
            halt_pend_d = 1'b0;
            sm_pend_d   = 1'b0;
            if (halt_pend_q || halt_req) cause_d = CauseHalt;
            else                         cause_d = CauseStep;
          end else if (mem_word == CmdEbreak) begin
            cmd     = CmdPark;
            state_d = StHalted;
            cause_d = CauseEbreak;
          end else begin
            cmd        = mem_word;
            inflight_d = 1'b1;
          end
        end else if (cpu_done) begin
          slot_d    = 1'b1;
          sm_pend_d = step_mode && inflight_q;
          if (inflight_q) retired_d = retired_q + 32'd1;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc == WdW'(TIMEOUT)) begin
            state_d = StFault;
            fcode_d = FaultTimeout;
          end
        end
      end

      StHalted: begin
        if (step) begin
          go_d      = 1'b1;
          go_step_d = 1'b1;
        end else if (resume) begin
          go_d = 1'b1;
        end
        if (slot_q) begin
          wdog_d = WdW'(1);
          cmd    = CmdPark;
          if (go_q) begin
            go_d      = 1'b0;
            go_step_d = 1'b0;
            if (pc_misaligned) begin
              state_d = StFault;
              fcode_d = FaultMisalign;
            end else if (pc_out_range) begin
              state_d = StFault;
              fcode_d = FaultRange;
            end else if (mem_word == CmdEbreak) begin
              cause_d = CauseEbreak;
            end else begin
              cmd         = mem_word;
              inflight_d  = 1'b1;
              state_d     = StRun;
              cause_d     = CauseNone;
              halt_pend_d = go_step_q;  // step: halt again at the following slot
            end
          end
        end else if (cpu_done) begin
          slot_d = 1'b1;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc == WdW'(TIMEOUT)) begin
            state_d = StFault;
            fcode_d = FaultTimeout;
          end
        end
        if (clear) begin
          state_d     = StIdle;
          cause_d     = CauseNone;
          slot_d      = 1'b0;
          go_d        = 1'b0;
          go_step_d   = 1'b0;
          halt_pend_d = 1'b0;
          inflight_d  = 1'b0;
        end
      end

      StFault: begin
        if (clear) begin
          state_d = StIdle;
          fcode_d = FaultNone;
          cause_d = CauseNone;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cause_q     <= CauseNone;
      fcode_q     <= FaultNone;
      slot_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      sm_pend_q   <= 1'b0;
      go_q        <= 1'b0;
      go_step_q   <= 1'b0;
      inflight_q  <= 1'b0;
      wdog_q      <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      fcode_q     <= fcode_d;
      slot_q      <= slot_d;
      halt_pend_q <= halt_pend_d;
      sm_pend_q   <= sm_pend_d;
      go_q        <= go_d;
      go_step_q   <= go_step_d;
      inflight_q  <= inflight_d;
      wdog_q      <= wdog_d;
      retired_q   <= retired_d;
    end
  end

  assign cpu_reset  = (state_q == StIdle) || (state_q == StFault);
  assign busy       = (state_q == StRun);
  assign halted     = (state_q == StHalted);
  assign fault      = (state_q == StFault);
  assign cause      = cause_q;
  assign fault_code = fcode_q;
  assign retired    = retired_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction-feed controller for the memory-less multicycle core (processor_no_mem).
- Holds a small word-addressed instruction store loaded over a write port, and tracks the core's PC (regValues[38]) and done pulse.
- Presents the correct command word in every fetch slot and controls the core's reset.
- Provides start, halt, single-step and resume; detects misaligned-PC, out-of-range-PC and hung-instruction faults.

Parameters:
- DEPTH, 64, instruction store size in 32-bit words.
- AW, 6, store address width; must equal clog2(DEPTH).
- TIMEOUT, 8, maximum cycles from a fetch slot to cpu_done before a fault is raised.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  store write strobe; honoured in IDLE only.
- load_addr  in  AW  store word address.
- load_data  in  32  store write data.
- start  in  1  pulse: leave IDLE and begin execution at PC 0.
- halt_req  in  1  pulse: halt after the in-flight instruction retires.
- step  in  1  pulse, in HALTED: execute exactly one instruction.
- resume  in  1  pulse, in HALTED: return to RUN.
- step_mode  in  1  level: halt after every retired instruction.
- clear  in  1  pulse: return from HALTED or FAULT to IDLE.
- cpu_pc  in  32  core PC (regValues[38]).
- cpu_done  in  1  core done.
- cmd  out  32  core command word.
- cpu_reset  out  1  core synchronous reset, active-high.
- busy  out  1  high in RUN.
- halted  out  1  high in HALTED.
- fault  out  1  high in FAULT.
- cause  out  2  0 none, 1 halt_req/step, 2 EBREAK, 3 step_mode.
- fault_code  out  2  0 none, 1 misaligned, 2 out of range, 3 timeout.
- retired  out  32  count of retired program instructions.

Behaviour:
- Reset (reset low): state=IDLE, cpu_reset=1, cmd=NOP (0x00000013). busy, halted and fault are 0. cause, fault_code and retired are 0. The store is not reset.
- Fetch slot: the cycle after cpu_reset deasserts, and the cycle after every cpu_done. The core latches cmd in that cycle (core state 0).
- cmd is combinational from a registered slot flag, the state and cpu_pc. Outside fetch slots cmd=NOP; the core ignores it.
- PARK = 0x00000063 (BEQ x0,x0,0). It is always taken with target PC+0 and writes no GPR. Fed in HALTED fetch slots so the core spins with its architectural state preserved.
- IDLE:
  - cpu_reset=1; load_en writes mem[load_addr]<=load_data.
  - start -> RUN, cpu_reset=0 next cycle, retired=0.
- RUN, per fetch slot, first match wins:
  - cpu_pc[1:0]!=0 -> FAULT, code 1.
  - cpu_pc[31:2]>=DEPTH -> FAULT, code 2.
  - a halt is pending (halt_req seen since the last slot, or step_mode at the previous retire) -> feed PARK, go HALTED, cause 1 or 3.
  - mem word is EBREAK (0x00100073) -> feed PARK, go HALTED, cause 2.
  - otherwise feed mem[cpu_pc[AW+1:2]].
- Retire: cpu_done while a program instruction is in flight -> retired+1. PARK completions never count. retired wraps at 2^32.
- Watchdog: counter clears at each fetch slot. Reaching TIMEOUT without cpu_done -> FAULT, code 3.
- HALTED:
  - PARK is fed each slot.
  - resume -> at the next slot, perform the RUN checks on cpu_pc, feed the instruction, go RUN, cause 0.
  - step -> same as resume but halts at the following slot, cause 1.
  - resume and step together -> step wins.
  - clear -> IDLE.
- FAULT: cpu_reset=1, cmd=NOP, fault_code is held; clear -> IDLE with fault_code=0.
- Pulses (start, resume, step) arriving in a state that ignores them are dropped. halt_req in HALTED, IDLE or FAULT is dropped.
- Same-cycle priority: reset > fault detection > halt > EBREAK.
- reset asserted mid-instruction returns to IDLE immediately. The core is held in reset from the next edge.

Decomposition:
- Shared package (proc_pkg): state enum (IDLE, RUN, HALTED, FAULT), NOP/PARK/EBREAK constants, cause and fault_code encodings. The core's opcode parameters move there too.
- One sub-module, seq_imem: DEPTH x 32 store, one synchronous write port, asynchronous read, no reset.
- FSM, slot flag, watchdog and retire counter stay in instr_sequencer.

Test Plan:
- Basic run with the real core:
  - Stimulus: load 0x00500093 (ADDI x1,x0,5) at 0, 0x00300113 (ADDI x2,x0,3) at 1, 0x002081B3 (ADD x3,x1,x2) at 2, EBREAK at 3; then start.
  - Response: x3=8, retired=3, halted=1, cause=2, cmd=PARK in slots, cpu_pc stays 0xC.
- halt_req then resume:
  - Stimulus: halt_req during instruction 1 of the same program.
  - Response: halts with retired=1, cause=1, x1=5, x2=0. resume gives the same final state as the basic run.
- step_mode:
  - Stimulus: step_mode=1 with the same program.
  - Response: halts after each retire (retired 1, 2, 3, cause=3); each step advances cpu_pc by 4.
- Out-of-range PC:
  - Stimulus: program 0x1000006F (JAL x0,0x100) with DEPTH=64.
  - Response: fault=1, fault_code=2, cpu_reset=1, retired=1. clear returns to IDLE.
- Watchdog (stub core):
  - Stimulus: cpu_done tied 0.
  - Response: fault_code=3 exactly TIMEOUT cycles after the first slot.
  - Stimulus: cpu_pc=0x2.
  - Response: fault_code=1 with no instruction fed.
- Reset mid-run, load gating:
  - Stimulus: drop reset during RUN.
  - Response: all outputs at reset values asynchronously, store contents intact on re-start.
  - Stimulus: load_en during RUN.
  - Response: ignored.
